reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Parametrised in-order retirement buffer for the out-of-order core; successor of the fixed 8-entry ROB.
//  Decoder allocates one entry per cycle and receives its tag; CDB marks entries complete.
//  Head retires in order to the register file; flush squashes all in-flight entries.
//  Two operand-lookup ports let the decoder pull ready values, with same-cycle CDB bypass.
// PARAMETERS
//  DEPTH    8   entry count, power of 2, >=2; TAG_W = $clog2(DEPTH)
//  DATA_W   32  result data width
//  REG_AW   5   architectural destination register index width
// PORTS
//  clk          in   1          clock, all state updates on rising edge
//  rst          in   1          reset, synchronous, active-high
//  flush        in   1          squash all entries (mispredict)
//  alloc_valid  in   1          decoder requests an entry
//  alloc_rd     in   REG_AW     destination register of the allocated entry
//  alloc_ready  out  1          entry available (count < DEPTH)
//  alloc_tag    out  TAG_W      tag granted = tail pointer
//  q1_valid     in   1          lookup 1 names a producer (0 = operand from regfile)
//  q1_tag       in   TAG_W      lookup 1 tag
//  q1_ready     out  1          lookup 1 value available
//  q1_data      out  DATA_W     lookup 1 value
//  q2_valid/q2_tag/q2_ready/q2_data  same as port 1 for second operand
//  cdb_valid    in   1          CDB broadcast valid
//  cdb_tag      in   TAG_W      CDB producer tag
//  cdb_data     in   DATA_W     CDB result
//  commit_valid out  1          registered: one entry retired last cycle
//  commit_rd    out  REG_AW     retired destination register
//  commit_data  out  DATA_W     retired value
//  commit_tag   out  TAG_W      retired tag (rename-table clear)
//  count        out  TAG_W+1    occupied entries
//  empty        out  1          count == 0
// BEHAVIOUR
//  - Entry = {valid, done, rd, data}. head/tail pointers TAG_W bits, wrap naturally mod DEPTH.
//  - Reset: head=tail=count=0, all valid/done=0, commit_valid=0, commit_rd/data/tag=0; alloc_ready=1, empty=1.
//  - Alloc: alloc_valid & alloc_ready -> entry[tail]={1,0,alloc_rd,0}, tail+1. alloc_tag valid same cycle (combinational).
//  - alloc_ready uses current count only; a commit in the same cycle does NOT free a slot for that cycle's alloc.
//  - CDB: cdb_valid & entry[cdb_tag].valid & !done -> data=cdb_data, done=1. CDB to invalid/done entry ignored.
//  - Commit: entry[head].valid & done -> next cycle commit_valid=1 with its rd/data/head tag; valid cleared, head+1.
//    At most one commit per cycle; CDB completing the head this cycle commits next cycle (no same-cycle commit).
//  - count next = count + alloc_fire - commit_fire; simultaneous alloc and commit leaves count unchanged.
//  - Lookup (combinational, per port): !qN_valid -> ready=1,data=0; cdb_valid & cdb_tag==qN_tag -> ready=1,data=cdb_data;
//    else ready=entry.done, data=entry.data. Data field is not cleared on commit.
//  - Flush: highest priority; next cycle head=tail=count=0, all valid/done=0, commit_valid=0.
//    Same-cycle alloc, CDB and commit are discarded. Reset dominates flush.
//  - No stall on the commit side; regfile always accepts.
// STRUCTURE
//  - Shared package rob_pkg: entry struct typedef, TAG_W derivation function, commit bundle typedef.
//  - One sub-module natural: rob_lookup (single operand lookup + CDB bypass), instantiated twice.
//  - Storage as flop arrays (valid/done need per-entry clear on flush); no SRAM.
// TESTING
//  1 Reset: after rst, count=0, empty=1, alloc_ready=1, alloc_tag=0, commit_valid=0.
//  2 Fill: 8 allocs rd=1..8 -> tags 0..7, count=8, alloc_ready=0; 9th alloc_valid ignored, tail stays 0.
//  3 Out-of-order CDB: complete tag2 (0xB), then tag0 (0xA) -> commit tag0 rd=1 data=0xA; tag1 unfinished blocks tag2.
//  4 Bypass: q1_tag=3 with cdb_tag=3,data=0x55 same cycle -> q1_ready=1,q1_data=0x55; q2_valid=0 -> ready=1,data=0.
//  5 Wrap + full concurrency: count=8, head done, alloc_valid=1 -> alloc refused, commit fires, count=7; next alloc tag wraps to 0.
//  6 Flush mid-flight: 5 entries, flush with cdb_valid and alloc_valid -> next cycle count=0, empty=1, no commit, alloc_tag=0.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer slice.
//   rob_tag_w   : tag width derived from the entry count
//   rob_flags_t : per-entry occupancy/completion flags
package rob_pkg;

    // Tag width for a DEPTH-entry buffer; never narrower than one bit.
    function automatic int unsigned rob_tag_w(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    typedef struct packed {
        logic valid;
        logic done;
    } rob_flags_t;

endpackage

// File: rtl/rob_lookup.sv
// Single operand lookup with same-cycle CDB bypass.
//   q_valid/q_tag   : operand producer request (q_valid=0 means operand comes from the regfile)
//   cdb_*           : result broadcast this cycle
//   done_vec/data_vec : per-entry completion flags and result data
//   q_ready/q_data  : operand availability and value
module rob_lookup
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 3
) (
    input  logic                          q_valid,
    input  logic [TAG_W-1:0]              q_tag,
    input  logic                          cdb_valid,
    input  logic [TAG_W-1:0]              cdb_tag,
    input  logic [DATA_W-1:0]             cdb_data,
    input  logic [DEPTH-1:0]              done_vec,
    input  logic [DEPTH-1:0][DATA_W-1:0]  data_vec,
    output logic                          q_ready,
    output logic [DATA_W-1:0]             q_data
);

    always_comb begin
        q_ready = 1'b1;
        q_data  = '0;
        if (q_valid) begin
            if (cdb_valid && (cdb_tag == q_tag)) begin
                q_ready = 1'b1;
                q_data  = cdb_data;
            end else begin
                q_ready = done_vec[q_tag];
                q_data  = data_vec[q_tag];
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: one allocation, one CDB completion and one
// commit per cycle; flush squashes every in-flight entry.
//   alloc_*  : decoder allocation handshake, tag = tail pointer
//   q1_*/q2_*: operand lookups with CDB bypass
//   cdb_*    : completion broadcast
//   commit_* : registered retirement of the head entry
//   count/empty : occupancy
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    localparam int unsigned TAG_W = rob_tag_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alloc_valid,
    input  logic [REG_AW-1:0] alloc_rd,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              q1_valid,
    input  logic [TAG_W-1:0]  q1_tag,
    output logic              q1_ready,
    output logic [DATA_W-1:0] q1_data,
    input  logic              q2_valid,
    input  logic [TAG_W-1:0]  q2_tag,
    output logic              q2_ready,
    output logic [DATA_W-1:0] q2_data,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              commit_valid,
    output logic [REG_AW-1:0] commit_rd,
    output logic [DATA_W-1:0] commit_data,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [TAG_W:0]    count,
    output logic              empty
);

    typedef struct packed {
        rob_flags_t        flags;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } commit_t;

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    logic [TAG_W-1:0]   head_q, head_d;
    logic [TAG_W-1:0]   tail_q, tail_d;
    logic [TAG_W:0]     count_q, count_d;
    commit_t            commit_q, commit_d;

    logic               alloc_fire;
    logic               commit_fire;
    logic               cdb_hit;
    logic [DEPTH-1:0]             done_vec;
    logic [DEPTH-1:0][DATA_W-1:0] data_vec;

    // Readiness looks at the current count only, so a same-cycle commit
    // never frees a slot for this cycle's allocation.
    assign alloc_ready = (count_q < FULL_COUNT);
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign commit_fire = ent_q[head_q].flags.valid && ent_q[head_q].flags.done;
    assign cdb_hit     = cdb_valid && ent_q[cdb_tag].flags.valid && !ent_q[cdb_tag].flags.done;

    always_comb begin
        ent_d    = ent_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        commit_d = commit_q;
        commit_d.valid = 1'b0;
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_d[i].flags = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (cdb_hit) begin
                ent_d[cdb_tag].flags.done = 1'b1;
                ent_d[cdb_tag].data       = cdb_data;
            end
            if (commit_fire) begin
                ent_d[head_q].flags.valid = 1'b0;
                head_d   = head_q + 1'b1;
                commit_d = '{valid: 1'b1, rd: ent_q[head_q].rd,
                             data: ent_q[head_q].data, tag: head_q};
            end
            // The tail slot is never the CDB target (invalid) nor the commit
            // target (head needs valid), so applying alloc last is safe.
            if (alloc_fire) begin
                ent_d[tail_q] = '{flags: '{valid: 1'b1, done: 1'b0},
                                  rd: alloc_rd, data: '0};
                tail_d = tail_q + 1'b1;
            end
            count_d = count_q + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, commit_fire};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            commit_q <= '0;
        end else begin
            ent_q    <= ent_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            commit_q <= commit_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            done_vec[i] = ent_q[i].flags.done;
            data_vec[i] = ent_q[i].data;
        end
    end

    rob_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_lookup1 (
        .q_valid   (q1_valid),
        .q_tag     (q1_tag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .done_vec  (done_vec),
        .data_vec  (data_vec),
        .q_ready   (q1_ready),
        .q_data    (q1_data)
    );

    rob_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_lookup2 (
        .q_valid   (q2_valid),
        .q_tag     (q2_tag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .done_vec  (done_vec),
        .data_vec  (data_vec),
        .q_ready   (q2_ready),
        .q_data    (q2_data)
    );

    assign alloc_tag    = tail_q;
    assign commit_valid = commit_q.valid;
    assign commit_rd    = commit_q.rd;
    assign commit_data  = commit_q.data;
    assign commit_tag   = commit_q.tag;
    assign count        = count_q;
    assign empty        = (count_q == '0);

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        q1_valid;
    logic [2:0]  q1_tag;
    logic        q1_ready;
    logic [31:0] q1_data;
    logic        q2_valid;
    logic [2:0]  q2_tag;
    logic        q2_ready;
    logic [31:0] q2_data;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic [2:0]  commit_tag;
    logic [3:0]  count;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    reorder_buffer #(.DEPTH(8), .DATA_W(32), .REG_AW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .alloc_valid  (alloc_valid),
        .alloc_rd     (alloc_rd),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .q1_valid     (q1_valid),
        .q1_tag       (q1_tag),
        .q1_ready     (q1_ready),
        .q1_data      (q1_data),
        .q2_valid     (q2_valid),
        .q2_tag       (q2_tag),
        .q2_ready     (q2_ready),
        .q2_data      (q2_data),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_data  (commit_data),
        .commit_tag   (commit_tag),
        .count        (count),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus the outputs expected while it is applied
    // (combinational outputs react to it; registered ones show prior state).
    typedef struct {
        logic        fl;
        logic        av;
        logic [4:0]  ard;
        logic        q1v;
        logic [2:0]  q1t;
        logic        q2v;
        logic [2:0]  q2t;
        logic        cv;
        logic [2:0]  ct;
        logic [31:0] cd;
        logic        e_ar;
        logic [2:0]  e_at;
        logic        e_q1r;
        logic [31:0] e_q1d;
        logic        e_q2r;
        logic [31:0] e_q2d;
        logic [3:0]  e_cnt;
        logic        e_cv;
        logic [4:0]  e_crd;
        logic [31:0] e_cdat;
        logic [2:0]  e_ctag;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush = 1'b0; alloc_valid = 1'b0; alloc_rd = '0;
        q1_valid = 1'b0; q1_tag = '0; q2_valid = 1'b0; q2_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Allocate one entry in the coming cycle, no checks.
    task automatic alloc_one(input logic [4:0] rd);
        @(negedge clk);
        idle();
        alloc_valid = 1'b1;
        alloc_rd    = rd;
    endtask

    task automatic apply_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        flush = v.fl; alloc_valid = v.av; alloc_rd = v.ard;
        q1_valid = v.q1v; q1_tag = v.q1t; q2_valid = v.q2v; q2_tag = v.q2t;
        cdb_valid = v.cv; cdb_tag = v.ct; cdb_data = v.cd;
        #1;
        chk($sformatf("v%0d alloc_ready", idx), 32'(alloc_ready), 32'(v.e_ar));
        chk($sformatf("v%0d alloc_tag", idx), 32'(alloc_tag), 32'(v.e_at));
        chk($sformatf("v%0d q1_ready", idx), 32'(q1_ready), 32'(v.e_q1r));
        chk($sformatf("v%0d q1_data", idx), q1_data, v.e_q1d);
        chk($sformatf("v%0d q2_ready", idx), 32'(q2_ready), 32'(v.e_q2r));
        chk($sformatf("v%0d q2_data", idx), q2_data, v.e_q2d);
        chk($sformatf("v%0d count", idx), 32'(count), 32'(v.e_cnt));
        chk($sformatf("v%0d empty", idx), 32'(empty), 32'(v.e_cnt == 4'd0));
        chk($sformatf("v%0d commit_valid", idx), 32'(commit_valid), 32'(v.e_cv));
        chk($sformatf("v%0d commit_rd", idx), 32'(commit_rd), 32'(v.e_crd));
        chk($sformatf("v%0d commit_data", idx), commit_data, v.e_cdat);
        chk($sformatf("v%0d commit_tag", idx), 32'(commit_tag), 32'(v.e_ctag));
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // Fill: rd=1..8 receive tags 0..7.
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{0, 1, 5'(i + 1), 0, 0, 0, 0, 0, 0, 0,
                        1, 3'(i), 1, 0, 1, 0, 4'(i), 0, 0, 0, 0};
        end
        // Full: 9th alloc refused; tag2 completes (bypass on q1), q2 sees tag0 not done.
        vecs[8]  = '{0, 1, 9, 1, 2, 1, 0, 1, 2, 'hB,   0, 0, 1, 'hB,  0, 0,     8, 0, 0, 0, 0};
        // tag0 completes; q1 reads stored tag2, q2 sees tag1 pending.
        vecs[9]  = '{0, 0, 0, 1, 2, 1, 1, 1, 0, 'hA,   0, 0, 1, 'hB,  0, 0,     8, 0, 0, 0, 0};
        // Bypass tag3 = 0x55; q2 unnamed operand. Head (tag0) commits this edge.
        vecs[10] = '{0, 0, 0, 1, 3, 0, 0, 1, 3, 'h55,  0, 0, 1, 'h55, 1, 0,     8, 0, 0, 0, 0};
        // Commit of tag0 visible; retired data still readable; tag1 blocks tag2.
        vecs[11] = '{0, 0, 0, 1, 0, 1, 3, 0, 0, 0,     1, 0, 1, 'hA,  1, 'h55,  7, 1, 1, 'hA, 0};
        // Commit pulse gone (fields held); tag1 completes with 0xC.
        vecs[12] = '{0, 0, 0, 1, 1, 1, 2, 1, 1, 'hC,   1, 0, 1, 'hC,  1, 'hB,   7, 0, 1, 'hA, 0};
        // tag1 commits this edge; tag5 still pending.
        vecs[13] = '{0, 0, 0, 1, 5, 0, 0, 0, 0, 0,     1, 0, 0, 0,    1, 0,     7, 0, 1, 'hA, 0};
        // Back-to-back retirement of tags 1,2,3.
        vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0, 1, 0,    1, 0,     6, 1, 2, 'hC, 1};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0, 1, 0,    1, 0,     5, 1, 3, 'hB, 2};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0, 1, 0,    1, 0,     4, 1, 4, 'h55, 3};
        // tag4 not done: retirement stops.
        vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0, 1, 0,    1, 0,     4, 0, 4, 'h55, 3};

        // Reset state.
        do_reset();
        chk("rst count", 32'(count), 0);
        chk("rst empty", 32'(empty), 1);
        chk("rst alloc_ready", 32'(alloc_ready), 1);
        chk("rst alloc_tag", 32'(alloc_tag), 0);
        chk("rst commit_valid", 32'(commit_valid), 0);
        chk("rst commit_rd", 32'(commit_rd), 0);
        chk("rst commit_data", commit_data, 0);
        chk("rst commit_tag", 32'(commit_tag), 0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            apply_vec(i);
        end

        // Full buffer with done head: alloc refused while commit fires, tail wraps.
        do_reset();
        for (int i = 0; i < 8; i++) alloc_one(5'(i + 1));
        @(negedge clk);
        idle();
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'h77;
        @(negedge clk);
        idle();
        alloc_valid = 1'b1; alloc_rd = 5'h1F;
        #1;
        chk("wrap full alloc_ready", 32'(alloc_ready), 0);
        chk("wrap full count", 32'(count), 8);
        @(negedge clk);
        alloc_rd = 5'h1E;
        #1;
        chk("wrap count after commit", 32'(count), 7);
        chk("wrap alloc_ready", 32'(alloc_ready), 1);
        chk("wrap alloc_tag", 32'(alloc_tag), 0);
        chk("wrap commit_valid", 32'(commit_valid), 1);
        chk("wrap commit_tag", 32'(commit_tag), 0);
        chk("wrap commit_rd", 32'(commit_rd), 1);
        chk("wrap commit_data", commit_data, 32'h77);
        @(negedge clk);
        idle();
        #1;
        chk("wrap refill count", 32'(count), 8);
        chk("wrap refill alloc_ready", 32'(alloc_ready), 0);
        chk("wrap refill alloc_tag", 32'(alloc_tag), 1);
        chk("wrap no commit", 32'(commit_valid), 0);

        // Flush with concurrent alloc, CDB and a ready head.
        do_reset();
        for (int i = 0; i < 5; i++) alloc_one(5'(i + 1));
        @(negedge clk);
        idle();
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'h99;
        @(negedge clk);
        idle();
        flush = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 32'h12;
        alloc_valid = 1'b1; alloc_rd = 5'd6;
        #1;
        chk("flush pre count", 32'(count), 5);
        @(negedge clk);
        idle();
        q1_valid = 1'b1; q1_tag = 3'd1;
        q2_valid = 1'b1; q2_tag = 3'd0;
        #1;
        chk("flush count", 32'(count), 0);
        chk("flush empty", 32'(empty), 1);
        chk("flush alloc_ready", 32'(alloc_ready), 1);
        chk("flush alloc_tag", 32'(alloc_tag), 0);
        chk("flush commit_valid", 32'(commit_valid), 0);
        chk("flush cdb discarded", 32'(q1_ready), 0);
        chk("flush done cleared", 32'(q2_ready), 0);
        @(negedge clk);
        idle();
        #1;
        chk("flush no late commit", 32'(commit_valid), 0);
        chk("flush count stays", 32'(count), 0);

        // Reset dominates flush and alloc.
        @(negedge clk);
        rst = 1'b1; flush = 1'b1; alloc_valid = 1'b1; alloc_rd = 5'd3;
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        chk("rst over alloc count", 32'(count), 0);
        chk("rst over alloc tag", 32'(alloc_tag), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
